// File: rtl/fp_unpk_pkg.sv
// rtl/fp_unpk_pkg.sv - shared types and constants for the fp_unpk operand unpacker
// Purpose: state encoding, fclass bit indices, per-format exponent limits and
//          hidden-bit positions, and the input/output bundle types.
package fp_unpk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // fclass bit indices (one-hot)
  localparam int FC_NINF  = 0;
  localparam int FC_NNORM = 1;
  localparam int FC_NSUB  = 2;
  localparam int FC_NZERO = 3;
  localparam int FC_PZERO = 4;
  localparam int FC_PSUB  = 5;
  localparam int FC_PNORM = 6;
  localparam int FC_PINF  = 7;
  localparam int FC_SNAN  = 8;
  localparam int FC_QNAN  = 9;

  // all-ones biased exponent per format
  localparam logic [10:0] EMAX_SP = 11'h0FF;
  localparam logic [10:0] EMAX_DP = 11'h7FF;

  // hidden-bit position inside the 54-bit mantissa
  localparam logic [5:0] HP_SP = 6'd23;
  localparam logic [5:0] HP_DP = 6'd52;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  fmt;
  } fp_unpk_in_type;

  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic [9:0]  fclass;
  } fp_unpk_out_type;

  function automatic logic [9:0] fc_onehot(input int idx);
    return 10'd1 << idx;
  endfunction

endpackage

// File: rtl/fp_unpk_lzc.sv
// rtl/fp_unpk_lzc.sv - leading-zero count below a movable hidden-bit position
// Purpose: counts zeros from bit hp_i downward to the first set bit of mant_i.
//          Returns hp_i+1 when nothing at or below hp_i is set.
// Ports:
//   mant_i  in  54  mantissa being normalised
//   hp_i    in  6   hidden-bit position (23 single, 52 double)
//   lz_o    out 6   zero count
module fp_unpk_lzc (
  input  logic [53:0] mant_i,
  input  logic [5:0]  hp_i,
  output logic [5:0]  lz_o
);

  // Scan upward so the last hit is the most significant set bit in range.
  always_comb begin
    lz_o = hp_i + 6'd1;
    for (int i = 0; i < 54; i++) begin
      if ((6'(i) <= hp_i) && mant_i[i]) begin
        lz_o = hp_i - 6'(i);
      end
    end
  end

endmodule

// File: rtl/fp_unpk.sv
// rtl/fp_unpk.sv - IEEE-754 single/double operand unpacker with iterative subnormal normalisation
// Purpose: splits a word into sign, biased exponent, hidden-bit mantissa, fclass
//          and special-case flags; subnormals are shifted up to STEP places per cycle.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready      input handshake (ready only in IDLE)
//   in_data[63:0], in_fmt  operand and format (0 single, 1 double, 2/3 reserved)
//   out_valid/out_ready    output handshake, result held until accepted
//   sig, expo[13:0], mant[53:0], fclass[9:0]  unpacked result
//   snan, qnan, inf, zero  special-case flags, consistent with fclass
module fp_unpk
  import fp_unpk_pkg::*;
#(
  parameter int STEP = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_fmt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sig,
  output logic [13:0] expo,
  output logic [53:0] mant,
  output logic [9:0]  fclass,
  output logic        snan,
  output logic        qnan,
  output logic        inf,
  output logic        zero
);

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t          state_q, state_d;
  fp_unpk_out_type res_q, res_d;
  logic            dbl_q, dbl_d;

  fp_unpk_in_type  in_w;
  logic            in_dbl, in_sgn, in_fmsb;
  logic [10:0]     in_exp, in_emax;
  logic [51:0]     in_frac;
  logic [53:0]     in_hid;

  logic [5:0]      hp, lz, sh;

  assign in_w = '{data: in_data, fmt: in_fmt};

  // Field extraction, right-aligned regardless of format.
  always_comb begin
    in_dbl = (in_w.fmt == 2'd1);
    if (in_dbl) begin
      in_sgn  = in_w.data[63];
      in_exp  = in_w.data[62:52];
      in_frac = in_w.data[51:0];
      in_fmsb = in_w.data[51];
      in_emax = EMAX_DP;
      in_hid  = 54'd1 << HP_DP;
    end else begin
      in_sgn  = in_w.data[31];
      in_exp  = {3'd0, in_w.data[30:23]};
      in_frac = {29'd0, in_w.data[22:0]};
      in_fmsb = in_w.data[22];
      in_emax = EMAX_SP;
      in_hid  = 54'd1 << HP_SP;
    end
  end

  assign hp = dbl_q ? HP_DP : HP_SP;

  fp_unpk_lzc u_lzc (
    .mant_i (res_q.mant),
    .hp_i   (hp),
    .lz_o   (lz)
  );

  assign sh = (lz > STEP_W) ? STEP_W : lz;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    dbl_d   = dbl_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          dbl_d   = in_dbl;
          if (in_w.fmt[1]) begin
            // reserved format: canonical quiet NaN with everything else cleared
            res_d        = '0;
            res_d.fclass = fc_onehot(FC_QNAN);
          end else begin
            res_d.sig = in_sgn;
            if (in_exp == in_emax) begin
              res_d.expo = {3'd0, in_exp};
              if (in_frac == '0) begin
                res_d.mant   = '0;
                res_d.fclass = fc_onehot(in_sgn ? FC_NINF : FC_PINF);
              end else begin
                res_d.mant   = {2'd0, in_frac};
                res_d.fclass = fc_onehot(in_fmsb ? FC_QNAN : FC_SNAN);
              end
            end else if (in_exp == '0) begin
              if (in_frac == '0) begin
                res_d.expo   = '0;
                res_d.mant   = '0;
                res_d.fclass = fc_onehot(in_sgn ? FC_NZERO : FC_PZERO);
              end else begin
                // subnormal: effective exponent 1, hidden bit absent
                res_d.expo   = 14'd1;
                res_d.mant   = {2'd0, in_frac};
                res_d.fclass = fc_onehot(in_sgn ? FC_NSUB : FC_PSUB);
                state_d      = NORM;
              end
            end else begin
              res_d.expo   = {3'd0, in_exp};
              res_d.mant   = {2'd0, in_frac} | in_hid;
              res_d.fclass = fc_onehot(in_sgn ? FC_NNORM : FC_PNORM);
            end
          end
        end
      end
      NORM: begin
        res_d.mant = res_q.mant << sh;
        res_d.expo = res_q.expo - {8'd0, sh};
        if (lz <= STEP_W) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dbl_q   <= dbl_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sig       = res_q.sig;
  assign expo      = res_q.expo;
  assign mant      = res_q.mant;
  assign fclass    = res_q.fclass;
  assign snan      = res_q.fclass[FC_SNAN];
  assign qnan      = res_q.fclass[FC_QNAN];
  assign inf       = res_q.fclass[FC_NINF] | res_q.fclass[FC_PINF];
  assign zero      = res_q.fclass[FC_NZERO] | res_q.fclass[FC_PZERO];

endmodule
